// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX frame writer: packs MAC bytes little-endian into 32-bit BRAM words,
// keeps whole word-aligned frames in a circular ring and queues good frames as descriptors.
module eth_rx_frame_ctrl #(
  parameter int C_DEPTH      = 1024,
  parameter int C_DESC_DEPTH = 8,
  parameter int C_MAX_BYTES  = 1522
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_areset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_last,
  input  logic                       rx_err,
  output logic                       bram_wr_en,
  output logic [$clog2(C_DEPTH)-1:0] bram_wr_addr,
  output logic [31:0]                bram_wr_data,
  output logic                       frame_avail,
  output logic [$clog2(C_DEPTH)-1:0] frame_base,
  output logic [15:0]                frame_len,
  input  logic                       frame_rel,
  output logic [$clog2(C_DEPTH):0]   ring_level,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(C_DESC_DEPTH);
  localparam logic [DW:0]   FIFO_FULL = C_DESC_DEPTH[DW:0];
  localparam logic [PW-1:0] RING_FULL = C_DEPTH[PW-1:0];
  localparam logic [15:0]   MAX_LEN   = C_MAX_BYTES[15:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_frm_start;
  logic [31:0]   r_pack;
  logic [1:0]    r_byte_idx;
  logic [15:0]   r_byte_cnt;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_frame_avail;
  logic [AW-1:0] r_frame_base;
  logic [15:0]   r_frame_len;
  logic [PW-1:0] r_ring_level;
  logic [15:0]   r_drop_cnt;
  logic [AW-1:0] r_desc_base [C_DESC_DEPTH];
  logic [15:0]   r_desc_len  [C_DESC_DEPTH];
  logic [DW-1:0] r_fwr, r_frd;
  logic [DW:0]   r_fcnt;

  logic [PW-1:0] w_used, w_start, w_wr_ptr_n, w_rd_ptr_n, w_rel_words;
  logic          w_full, w_first, w_byte, w_cmpl, w_long, w_ovf, w_abort;
  logic          w_wr, w_push, w_pop, w_drop;
  logic [1:0]    w_idx;
  logic [15:0]   w_cnt;
  logic [31:0]   w_word;
  logic [17:0]   w_len_rnd;
  logic [DW-1:0] w_frd_n;
  logic [DW:0]   w_fcnt_n;

  always_comb begin
    w_used   = r_wr_ptr - r_rd_ptr;
    w_full   = (r_fcnt == FIFO_FULL);
    w_first  = (r_state == S_IDLE);
    w_byte   = rx_valid && ((r_state == S_RECV) || (w_first && !w_full));
    w_idx    = w_first ? 2'd0 : r_byte_idx;
    w_cnt    = w_first ? 16'd1 : r_byte_cnt + 16'd1;
    w_start  = w_first ? r_wr_ptr : r_frm_start;
    w_word   = w_first ? 32'h0 : r_pack;
    w_word[{w_idx, 3'b000} +: 8] = rx_data;
    w_cmpl   = w_byte && ((w_idx == 2'd3) || rx_last);
    w_long   = w_byte && (w_cnt > MAX_LEN);
    // A word is only refused when the ring is completely full at the moment it completes.
    w_ovf    = w_cmpl && (w_used == RING_FULL);
    w_abort  = w_long || w_ovf || (w_byte && rx_last && rx_err);
    w_wr     = w_cmpl && !w_abort;
    w_push   = w_wr && rx_last;
    w_pop    = frame_rel && r_frame_avail;
    w_drop   = (rx_valid && w_first && w_full) || w_abort;
    w_len_rnd   = {2'b00, r_frame_len} + 18'd3;
    w_rel_words = PW'(w_len_rnd >> 2);
    w_wr_ptr_n  = w_abort ? w_start : (w_wr ? r_wr_ptr + PW'(1) : r_wr_ptr);
    w_rd_ptr_n  = w_pop ? r_rd_ptr + w_rel_words : r_rd_ptr;
    w_frd_n     = w_pop ? r_frd + DW'(1) : r_frd;
    w_fcnt_n    = r_fcnt + {{DW{1'b0}}, w_push} - {{DW{1'b0}}, w_pop};
  end

  always_ff @(posedge s_axi_aclk)
    if (w_push) begin
      r_desc_base[r_fwr] <= w_start[AW-1:0];
      r_desc_len[r_fwr]  <= w_cnt;
    end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_frm_start   <= '0;
      r_pack        <= '0;
      r_byte_idx    <= '0;
      r_byte_cnt    <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_avail <= 1'b0;
      r_frame_base  <= '0;
      r_frame_len   <= '0;
      r_ring_level  <= '0;
      r_drop_cnt    <= '0;
      r_fwr         <= '0;
      r_frd         <= '0;
      r_fcnt        <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_wr_ptr[AW-1:0];
        r_wr_data <= w_word;
      end
      r_wr_ptr     <= w_wr_ptr_n;
      r_rd_ptr     <= w_rd_ptr_n;
      r_ring_level <= w_wr_ptr_n - w_rd_ptr_n;

      if (rx_valid && w_first && w_full)
        r_state <= rx_last ? S_IDLE : S_DROP;
      else if (w_byte) begin
        if (rx_last)      r_state <= S_IDLE;
        else if (w_abort) r_state <= S_DROP;
        else              r_state <= S_RECV;
      end else if ((r_state == S_DROP) && rx_valid && rx_last)
        r_state <= S_IDLE;

      if (w_byte && w_first) r_frm_start <= r_wr_ptr;
      if (w_byte) begin
        r_byte_cnt <= w_cnt;
        if (w_cmpl || w_abort) begin
          r_pack     <= '0;
          r_byte_idx <= '0;
        end else begin
          r_pack     <= w_word;
          r_byte_idx <= w_idx + 2'd1;
        end
      end

      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

      if (w_push) r_fwr <= r_fwr + DW'(1);
      r_frd  <= w_frd_n;
      r_fcnt <= w_fcnt_n;
      // Head registers track the post-update FIFO; a push into an empty FIFO bypasses the array.
      r_frame_avail <= (w_fcnt_n != '0);
      if (w_fcnt_n == '0) begin
        r_frame_base <= '0;
        r_frame_len  <= '0;
      end else if (w_push && (r_fwr == w_frd_n)) begin
        r_frame_base <= w_start[AW-1:0];
        r_frame_len  <= w_cnt;
      end else begin
        r_frame_base <= r_desc_base[w_frd_n];
        r_frame_len  <= r_desc_len[w_frd_n];
      end
    end
  end

  assign bram_wr_en   = r_wr_en;
  assign bram_wr_addr = r_wr_addr;
  assign bram_wr_data = r_wr_data;
  assign frame_avail  = r_frame_avail;
  assign frame_base   = r_frame_base;
  assign frame_len    = r_frame_len;
  assign ring_level   = r_ring_level;
  assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: directed scenarios plus randomized frames checked against
// a frame-level model of the ring (word counts, descriptor queue, drop counter).
module tb_eth_rx_frame_ctrl;
  localparam int DEPTH = 16, DDEPTH = 4, MAXB = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, rx_err, frame_rel;
  logic        bram_wr_en;
  logic [3:0]  bram_wr_addr;
  logic [31:0] bram_wr_data;
  logic        frame_avail;
  logic [3:0]  frame_base;
  logic [15:0] frame_len;
  logic [4:0]  ring_level;
  logic [15:0] drop_cnt;

  int n_pass = 0, n_total = 0;
  logic [7:0]  fb [64];
  logic [31:0] shadow [DEPTH];
  int wr_cnt = 0;
  int wr_addrs[$];
  int m_wr, m_rd, m_drop;
  int q_base[$], q_len[$];

  always #5 clk = ~clk;

  eth_rx_frame_ctrl #(.C_DEPTH(DEPTH), .C_DESC_DEPTH(DDEPTH), .C_MAX_BYTES(MAXB)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_err(rx_err),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .frame_avail(frame_avail), .frame_base(frame_base), .frame_len(frame_len),
    .frame_rel(frame_rel), .ring_level(ring_level), .drop_cnt(drop_cnt)
  );

  always @(negedge clk)
    if (bram_wr_en) begin
      shadow[bram_wr_addr] = bram_wr_data;
      wr_cnt++;
      wr_addrs.push_back(int'(bram_wr_addr));
    end

  task automatic do_reset();
    rst = 1'b1; rx_valid = 0; rx_last = 0; rx_err = 0; rx_data = 0; frame_rel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_wr = 0; m_rd = 0; m_drop = 0;
    q_base.delete(); q_len.delete();
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
  endtask

  task automatic send_frame(input int len, input bit err, input bit rel_last, input bit with_last);
    for (int i = 0; i < len; i++) begin
      rx_valid  = 1'b1;
      rx_data   = fb[i];
      rx_last   = with_last && (i == len - 1);
      rx_err    = err && rx_last;
      frame_rel = rel_last && rx_last;
      @(posedge clk); #1;
    end
    rx_valid = 0; rx_last = 0; rx_err = 0; rx_data = 0; frame_rel = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_one();
    frame_rel = 1'b1;
    @(posedge clk); #1 frame_rel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int len, input int w);
    logic [31:0] v = 32'h0;
    for (int b = 0; b < 4; b++)
      if (4 * w + b < len) v[8 * b +: 8] = fb[4 * w + b];
    return v;
  endfunction

  // Frame-level outcome: a frame is kept only if a descriptor slot is free, it is not
  // too long, all of its words fit in the free ring space and it carries no error.
  task automatic model_frame(input int len, input bit err, output bit ok);
    int words = (len + 3) / 4;
    ok = (q_len.size() < DDEPTH) && (len <= MAXB) && ((m_wr - m_rd) + words <= DEPTH) && !err;
    if (ok) begin
      q_base.push_back(m_wr % DEPTH);
      q_len.push_back(len);
      m_wr += words;
    end else m_drop++;
  endtask

  task automatic model_release();
    if (q_len.size() > 0) begin
      m_rd += (q_len[0] + 3) / 4;
      void'(q_base.pop_front());
      void'(q_len.pop_front());
    end
  endtask

  task automatic test_reset();
    do_reset();
    if ({bram_wr_en, frame_avail, frame_base, frame_len, ring_level, drop_cnt} !== '0)
      $display("FAIL reset_outputs: got %0h exp 0",
               {bram_wr_en, frame_avail, frame_base, frame_len, ring_level, drop_cnt});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 6; i++) fb[i] = 8'(i + 1);
    wr_addrs.delete();
    send_frame(6, 0, 0, 1);
    if (wr_addrs.size() != 2 || wr_addrs[0] != 0 || wr_addrs[1] != 1)
      $display("FAIL basic_addrs: got %0d writes exp 2 at 0,1", wr_addrs.size());
    else n_pass++;
    n_total++;
    if (shadow[0] !== 32'h04030201 || shadow[1] !== 32'h00000605)
      $display("FAIL basic_data: got %h %h exp 04030201 00000605", shadow[0], shadow[1]);
    else n_pass++;
    n_total++;
    if (frame_avail !== 1'b1 || frame_base !== 4'd0 || frame_len !== 16'd6 || ring_level !== 5'd2)
      $display("FAIL basic_desc: got avail=%b base=%0d len=%0d lvl=%0d exp 1 0 6 2",
               frame_avail, frame_base, frame_len, ring_level);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_error();
    do_reset();
    fill(8);
    send_frame(8, 1, 0, 1);
    if (frame_avail !== 1'b0 || drop_cnt !== 16'd1 || ring_level !== 5'd0)
      $display("FAIL err_drop: got avail=%b drop=%0d lvl=%0d exp 0 1 0", frame_avail, drop_cnt, ring_level);
    else n_pass++;
    n_total++;
    fill(4);
    send_frame(4, 0, 0, 1);
    if (frame_avail !== 1'b1 || frame_base !== 4'd0 || frame_len !== 16'd4)
      $display("FAIL err_next: got avail=%b base=%0d len=%0d exp 1 0 4", frame_avail, frame_base, frame_len);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int f = 0; f < 3; f++) begin fill(24); send_frame(24, 0, 0, 1); end
    if (drop_cnt !== 16'd1 || ring_level !== 5'd12 || frame_base !== 4'd0 || frame_len !== 16'd24)
      $display("FAIL ovf_drop: got drop=%0d lvl=%0d base=%0d len=%0d exp 1 12 0 24",
               drop_cnt, ring_level, frame_base, frame_len);
    else n_pass++;
    n_total++;
    release_one();
    if (ring_level !== 5'd6 || frame_base !== 4'd6)
      $display("FAIL ovf_rel: got lvl=%0d base=%0d exp 6 6", ring_level, frame_base);
    else n_pass++;
    n_total++;
    fill(24);
    wr_addrs.delete();
    send_frame(24, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (wr_addrs.size() != 6 || wr_addrs[i] != (12 + i) % DEPTH || shadow[(12 + i) % DEPTH] !== exp_word(24, i))
        $display("FAIL ovf_wrap_w%0d: got addr=%0d data=%h exp addr=%0d data=%h", i,
                 (wr_addrs.size() > i) ? wr_addrs[i] : -1, shadow[(12 + i) % DEPTH], (12 + i) % DEPTH, exp_word(24, i));
      else n_pass++;
      n_total++;
    end
    release_one();
    if (ring_level !== 5'd6 || frame_base !== 4'd12 || frame_len !== 16'd24)
      $display("FAIL ovf_fourth: got lvl=%0d base=%0d len=%0d exp 6 12 24", ring_level, frame_base, frame_len);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_desc_full();
    int w0;
    do_reset();
    for (int f = 0; f < DDEPTH; f++) begin fill(4); send_frame(4, 0, 0, 1); end
    w0 = wr_cnt;
    fill(4);
    send_frame(4, 0, 0, 1);
    if (wr_cnt != w0 || drop_cnt !== 16'd1 || ring_level !== 5'(DDEPTH))
      $display("FAIL full_drop: got writes=%0d drop=%0d lvl=%0d exp 0 1 %0d", wr_cnt - w0, drop_cnt, ring_level, DDEPTH);
    else n_pass++;
    n_total++;
    for (int f = 0; f < DDEPTH; f++) begin
      if (frame_avail !== 1'b1 || frame_base !== 4'(f))
        $display("FAIL full_desc%0d: got avail=%b base=%0d exp 1 %0d", f, frame_avail, frame_base, f);
      else n_pass++;
      n_total++;
      release_one();
    end
    if (frame_avail !== 1'b0 || ring_level !== 5'd0)
      $display("FAIL full_empty: got avail=%b lvl=%0d exp 0 0", frame_avail, ring_level);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_same_cycle();
    bit stayed = 1'b1;
    do_reset();
    fill(8); send_frame(8, 0, 0, 1);
    fill(12);
    for (int i = 0; i < 12; i++) begin
      rx_valid = 1'b1; rx_data = fb[i]; rx_last = (i == 11); rx_err = 0; frame_rel = (i == 11);
      @(posedge clk); #1;
    end
    rx_valid = 0; rx_last = 0; frame_rel = 0;
    for (int c = 0; c < 3; c++) begin
      if (frame_avail !== 1'b1) stayed = 1'b0;
      @(posedge clk); #1;
    end
    if (!stayed || frame_base !== 4'd2 || frame_len !== 16'd12 || ring_level !== 5'd3)
      $display("FAIL same_cycle: got stayed=%b base=%0d len=%0d lvl=%0d exp 1 2 12 3",
               stayed, frame_base, frame_len, ring_level);
    else n_pass++;
    n_total++;
    release_one();
    release_one();
    if (frame_avail !== 1'b0 || ring_level !== 5'd0)
      $display("FAIL rel_empty: got avail=%b lvl=%0d exp 0 0", frame_avail, ring_level);
    else n_pass++;
    n_total++;
    fill(4); send_frame(4, 0, 0, 1);
    if (frame_base !== 4'd5 || ring_level !== 5'd1)
      $display("FAIL rel_empty_ptr: got base=%0d lvl=%0d exp 5 1", frame_base, ring_level);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(10); send_frame(10, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fill(4); send_frame(4, 0, 0, 1);
    if (frame_avail !== 1'b1 || frame_base !== 4'd0 || frame_len !== 16'd4 || drop_cnt !== 16'd0 || ring_level !== 5'd1)
      $display("FAIL reset_mid: got avail=%b base=%0d len=%0d drop=%0d lvl=%0d exp 1 0 4 0 1",
               frame_avail, frame_base, frame_len, drop_cnt, ring_level);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_max_len();
    do_reset();
    fill(MAXB + 1); send_frame(MAXB + 1, 0, 0, 1);
    if (drop_cnt !== 16'd1 || ring_level !== 5'd0 || frame_avail !== 1'b0)
      $display("FAIL too_long: got drop=%0d lvl=%0d avail=%b exp 1 0 0", drop_cnt, ring_level, frame_avail);
    else n_pass++;
    n_total++;
    fill(MAXB); send_frame(MAXB, 0, 0, 1);
    if (frame_base !== 4'd0 || frame_len !== 16'(MAXB) || ring_level !== 5'd10 || shadow[9] !== exp_word(MAXB, 9))
      $display("FAIL max_len: got base=%0d len=%0d lvl=%0d w9=%h exp 0 %0d 10 %h",
               frame_base, frame_len, ring_level, shadow[9], MAXB, exp_word(MAXB, 9));
    else n_pass++;
    n_total++;
  endtask

  task automatic test_random();
    int nrel, len, w0, wds;
    bit err, full, ok;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      nrel = $urandom_range(0, 2);
      for (int r = 0; r < nrel; r++) begin release_one(); model_release(); end
      len  = $urandom_range(2, MAXB + 4);
      err  = ($urandom_range(0, 7) == 0);
      fill(len);
      full = (q_len.size() == DDEPTH);
      model_frame(len, err, ok);
      w0 = wr_cnt;
      send_frame(len, err, 0, 1);
      if (drop_cnt !== 16'(m_drop) || ring_level !== 5'(m_wr - m_rd) || frame_avail !== (q_len.size() > 0))
        $display("FAIL rand_state f=%0d: got drop=%0d lvl=%0d avail=%b exp %0d %0d %b", f,
                 drop_cnt, ring_level, frame_avail, m_drop, m_wr - m_rd, q_len.size() > 0);
      else n_pass++;
      n_total++;
      if (q_len.size() > 0) begin
        if (frame_base !== 4'(q_base[0]) || frame_len !== 16'(q_len[0]))
          $display("FAIL rand_head f=%0d: got base=%0d len=%0d exp %0d %0d", f, frame_base, frame_len, q_base[0], q_len[0]);
        else n_pass++;
        n_total++;
      end
      if (ok) begin
        wds = (len + 3) / 4;
        for (int w = 0; w < wds; w++) begin
          if (shadow[(q_base[$] + w) % DEPTH] !== exp_word(len, w))
            $display("FAIL rand_data f=%0d w=%0d: got %h exp %h", f, w, shadow[(q_base[$] + w) % DEPTH], exp_word(len, w));
          else n_pass++;
          n_total++;
        end
      end
      if (full) begin
        if (wr_cnt != w0) $display("FAIL rand_full_writes f=%0d: got %0d exp 0", f, wr_cnt - w0);
        else n_pass++;
        n_total++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_overflow();
    test_desc_full();
    test_same_cycle();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Write-side controller for the Ethernet RX frame BRAM. Accepts a byte stream from the MAC and packs it into 32-bit words, little-endian, on the BRAM write port. The BRAM is managed as a circular buffer of whole frames, and each frame starts word-aligned. The block commits good frames to a descriptor FIFO that host logic reads, rewinds the write pointer over bad or overflowing frames, and frees ring space when the host releases a frame.

Parameters:
C_DEPTH, 1024, BRAM depth in 32-bit words; power of two; ≥4.
C_DESC_DEPTH, 8, descriptor FIFO entries; power of two; ≥2.
C_MAX_BYTES, 1522, maximum accepted frame length in bytes.

Ports:
s_axi_aclk  in  1  clock; all logic on its rising edge.
s_axi_areset  in  1  synchronous reset, active-high.
rx_data  in  8  MAC RX byte.
rx_valid  in  1  rx_data valid this cycle.
rx_last  in  1  last byte of frame; qualified by rx_valid.
rx_err  in  1  frame error (bad FCS/PHY error); sampled only with rx_valid&rx_last.
bram_wr_en  out  1  BRAM word write strobe.
bram_wr_addr  out  $clog2(C_DEPTH)  BRAM word index.
bram_wr_data  out  32  packed word; byte0 in [7:0].
frame_avail  out  1  descriptor FIFO non-empty.
frame_base  out  $clog2(C_DEPTH)  word index of head frame.
frame_len  out  16  byte length of head frame.
frame_rel  in  1  one-cycle pulse: pop head descriptor and free its words.
ring_level  out  $clog2(C_DEPTH)+1  words in use (committed + in-flight).
drop_cnt  out  16  dropped-frame counter; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0. State IDLE, pointers 0, FIFO empty, packing register cleared. A frame interrupted by reset is discarded; bytes arriving after reset start a new frame.
- Pointers: wr_ptr, rd_ptr and frm_start are $clog2(C_DEPTH)+1 bits wide (wrap bit). used = wr_ptr − rd_ptr. The address is the low bits of the pointer, so the ring wraps naturally across the top of the BRAM.
- FSM IDLE:
  - rx_valid with descriptor FIFO full → DROP. drop_cnt++ when the drop is entered. A 1-byte frame (rx_last on the first byte) is dropped immediately and the FSM stays in IDLE.
  - rx_valid otherwise → RECV. frm_start := wr_ptr; the byte is packed.
- FSM RECV:
  - Bytes are packed at byte_idx 0..3.
  - A word completes on byte_idx==3 or on rx_last. Unreceived bytes of that word are 0.
  - On word completion, bram_wr_en is pulsed the next cycle (1-cycle latency) with addr = wr_ptr, and wr_ptr increments.
  - Overflow: a word that completes while used == C_DEPTH is not written. wr_ptr := frm_start → DROP (or IDLE if rx_last).
  - Length: a byte count exceeding C_MAX_BYTES is handled exactly like overflow.
  - Commit: rx_last with !rx_err and no overflow pushes {frm_start, len} into the FIFO → IDLE. The final word's write and the push land in the same cycle.
  - rx_last with rx_err: wr_ptr := frm_start, drop_cnt++ → IDLE. Any already-written words remain in the BRAM but are unreferenced.
- FSM DROP: ignores all bytes; no writes. rx_valid&rx_last → IDLE.
- Release:
  - frame_rel with frame_avail pops the head descriptor; rd_ptr += ceil(frame_len/4).
  - frame_rel with frame_avail=0 is ignored.
- Release and commit in the same cycle both take effect. FIFO occupancy is unchanged; frame_avail stays 1.
- frame_avail, frame_base and frame_len are registered FIFO head outputs. They update the cycle after a push into an empty FIFO or after a pop.
- ring_level = used, registered.
- No back-pressure to the MAC exists; the block must accept one byte every cycle indefinitely.

Test Plan:
1. Basic packing: 6-byte frame 01..06, no error → writes addr0=0x04030201 and addr1=0x00000605; frame_avail=1, base=0, len=6, ring_level=2.
2. Error frame: 8-byte frame with rx_err on last → no descriptor, drop_cnt=1. Next 4-byte frame gets base=0, len=4.
3. Ring overflow and wrap (C_DEPTH=16):
   - Three 24-byte frames, no release → frames 1–2 committed (bases 0, 6); frame 3 overflows at its 5th word and is dropped; drop_cnt=1, ring_level=12.
   - frame_rel → ring_level=6.
   - Fourth 24-byte frame → base=12, writes addr 12..15,0,1.
4. Descriptor full (C_DESC_DEPTH=2): three 4-byte frames, no release → third dropped with no writes; drop_cnt=1; two descriptors remain.
5. Same-cycle events: frame_rel asserted in the same cycle as the final rx_last of a committing frame → one pop and one push; frame_avail stays 1; ring_level correct. frame_rel with an empty FIFO → no change.
6. Reset mid-frame: assert s_axi_areset after 10 bytes of a frame, then send a 4-byte frame → base=0, len=4, drop_cnt=0. Separately, a 1523-byte frame with C_MAX_BYTES=1522 → dropped, wr_ptr restored.
